decoder_3to8: RTL and testbench

- Registered binary-to-one-hot decoder: 3-bit index in, 8-bit one-hot out.
- Generic in width (IN_W); the output is 2**IN_W bits.
- Used wherever a small index selects one of N enables/strobes: register-file write enables, mux selects, chip selects.
- Single clock domain. One-cycle latency. Adds enable gating, output polarity select, a valid flag and a change strobe.

---
 rtl/decoder_3to8.sv | 71 +++++++
 tb/tb_decoder_3to8.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/decoder_3to8.sv
// Registered binary-to-one-hot decoder with enable gating, polarity select, valid flag and change strobe.
// Define DECODER_ONEHOT_CHK_EN to add the registered onehot_err integrity flag.
module decoder_3to8 #(
    parameter int IN_W          = 3,
    parameter int ACTIVE_LOW    = 0,
    parameter int ZERO_WHEN_DIS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [IN_W-1:0]        in,
    output logic [(1<<IN_W)-1:0]   out,
    output logic [IN_W-1:0]        out_idx,
    output logic                   out_vld,
    output logic                   chg
`ifdef DECODER_ONEHOT_CHK_EN
    ,
    output logic                   onehot_err
`endif
);

    localparam int OUT_W = 1 << IN_W;
    localparam logic [OUT_W-1:0] IDLE = {OUT_W{ACTIVE_LOW != 0}};

    logic [OUT_W-1:0] decoded;

    // XOR with the idle pattern gives one-cold for ACTIVE_LOW=1.
    always_comb begin
        decoded = '0;
        decoded = (OUT_W'(1) << in) ^ IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= IDLE;
            out_idx <= '0;
            out_vld <= 1'b0;
            chg     <= 1'b0;
        end else if (en) begin
            out     <= decoded;
            out_idx <= in;
            out_vld <= 1'b1;
            chg     <= !out_vld || (in != out_idx);
        end else begin
            chg <= 1'b0;
            if (ZERO_WHEN_DIS != 0) begin
                out     <= IDLE;
                out_vld <= 1'b0;
            end
        end
    end

`ifdef DECODER_ONEHOT_CHK_EN
    logic [OUT_W-1:0] active;
    logic             single_bit;

    always_comb begin
        active     = out ^ IDLE;
        single_bit = (active != '0) && ((active & (active - OUT_W'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_err <= 1'b0;
        end else begin
            onehot_err <= out_vld ? !single_bit : (out != IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: default, active-low and hold-mode instances on shared stimulus.
module tb_decoder_3to8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [2:0] in  = 3'd5;

    logic [7:0] m_out,  a_out,  h_out;
    logic [2:0] m_idx,  a_idx,  h_idx;
    logic       m_vld,  a_vld,  h_vld;
    logic       m_chg,  a_chg,  h_chg;
`ifdef DECODER_ONEHOT_CHK_EN
    logic       m_err,  a_err,  h_err;
`endif

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    decoder_3to8 u_main (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(m_out), .out_idx(m_idx), .out_vld(m_vld), .chg(m_chg)
`ifdef DECODER_ONEHOT_CHK_EN
        , .onehot_err(m_err)
`endif
    );

    decoder_3to8 #(.ACTIVE_LOW(1)) u_al (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(a_out), .out_idx(a_idx), .out_vld(a_vld), .chg(a_chg)
`ifdef DECODER_ONEHOT_CHK_EN
        , .onehot_err(a_err)
`endif
    );

    decoder_3to8 #(.ZERO_WHEN_DIS(0)) u_hd (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .out(h_out), .out_idx(h_idx), .out_vld(h_vld), .chg(h_chg)
`ifdef DECODER_ONEHOT_CHK_EN
        , .onehot_err(h_err)
`endif
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] in;
        logic [7:0] out;
        logic [2:0] idx;
        logic       vld;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
`ifdef DECODER_ONEHOT_CHK_EN
        chk("onehot_err_main", {7'd0, m_err}, 8'h00);
        chk("onehot_err_al",   {7'd0, a_err}, 8'h00);
        chk("onehot_err_hold", {7'd0, h_err}, 8'h00);
`endif
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] i);
        rst = r;
        en  = e;
        in  = i;
    endtask

    initial begin
        // reset for two cycles with en=1, in=5
        vecs.push_back('{1'b1, 1'b1, 3'd5, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 8'h00, 3'd0, 1'b0, 1'b0});
        // sweep 0..7
        vecs.push_back('{1'b0, 1'b1, 3'd0, 8'h01, 3'd0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 8'h02, 3'd1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd2, 8'h04, 3'd2, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 8'h08, 3'd3, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 8'h10, 3'd4, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 8'h20, 3'd5, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 8'h40, 3'd6, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 8'h80, 3'd7, 1'b1, 1'b1});
        // 7 -> 0 wrap
        vecs.push_back('{1'b0, 1'b1, 3'd0, 8'h01, 3'd0, 1'b1, 1'b1});
        // repeat in=3, then disable, then re-enable
        vecs.push_back('{1'b0, 1'b1, 3'd3, 8'h08, 3'd3, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'd5, 8'h00, 3'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 8'h08, 3'd3, 1'b1, 1'b1});
        // mid-stream reset at in=4
        vecs.push_back('{1'b0, 1'b1, 3'd2, 8'h04, 3'd2, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 8'h20, 3'd5, 1'b1, 1'b1});
        // X on in while disabled stays out of out
        vecs.push_back('{1'b0, 1'b0, 3'bxxx, 8'h00, 3'd5, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 8'h80, 3'd7, 1'b1, 1'b1});

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].en, vecs[k].in);
            step();
            chk($sformatf("out[%0d]", k),     m_out,               vecs[k].out);
            chk($sformatf("out_idx[%0d]", k), {5'd0, m_idx},       {5'd0, vecs[k].idx});
            chk($sformatf("out_vld[%0d]", k), {7'd0, m_vld},       {7'd0, vecs[k].vld});
            chk($sformatf("chg[%0d]", k),     {7'd0, m_chg},       {7'd0, vecs[k].chg});
        end

        // Active-low polarity
        drive(1'b1, 1'b1, 3'd0);
        step();
        chk("al_reset_out", a_out, 8'hFF);
        chk("al_reset_vld", {7'd0, a_vld}, 8'h00);
        drive(1'b0, 1'b1, 3'd2);
        step();
        chk("al_in2_out", a_out, 8'hFB);
        chk("al_in2_chg", {7'd0, a_chg}, 8'h01);
        drive(1'b0, 1'b0, 3'd2);
        step();
        chk("al_dis_out", a_out, 8'hFF);
        chk("al_dis_vld", {7'd0, a_vld}, 8'h00);

        // Hold mode: out/out_idx/out_vld hold while disabled, in toggling
        drive(1'b0, 1'b1, 3'd6);
        step();
        chk("hd_dec_out", h_out, 8'h40);
        chk("hd_dec_chg", {7'd0, h_chg}, 8'h01);
        for (int unsigned t = 0; t < 3; t++) begin
            drive(1'b0, 1'b0, (t == 0) ? 3'd1 : (t == 1) ? 3'd7 : 3'd0);
            step();
            chk($sformatf("hd_hold_out[%0d]", t), h_out, 8'h40);
            chk($sformatf("hd_hold_idx[%0d]", t), {5'd0, h_idx}, 8'h06);
            chk($sformatf("hd_hold_vld[%0d]", t), {7'd0, h_vld}, 8'h01);
            chk($sformatf("hd_hold_chg[%0d]", t), {7'd0, h_chg}, 8'h00);
        end
        // same index after a hold is not a change
        drive(1'b0, 1'b1, 3'd6);
        step();
        chk("hd_same_chg", {7'd0, h_chg}, 8'h00);
        chk("hd_same_out", h_out, 8'h40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
